pll_supervisor: RTL and testbench



---
 rtl/pll_supervisor_pkg.sv | 30 +++
 rtl/pll_supervisor_sync_2ff.sv | 30 +++
 rtl/pll_supervisor.sv | 193 +++++++++++++++++++
 tb/tb_pll_supervisor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_supervisor_pkg
// Brief    : Shared types and sizing helpers for the PLL supervisor.
// Revision : 1.0
// ============================================================================
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam int unsigned c_llc_w = 8;

  // Counter width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int unsigned f_cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_supervisor_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous level.
// Revision : 1.0
// ============================================================================
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_supervisor
// Brief    : PLL reset/lock sequencer with retry, fault latch and staged
//            release of downstream reset domains.
// Revision : 1.0
// ============================================================================
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 120_000,
  parameter int unsigned PLL_RESET_CYCLES    = 12,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned NUM_DOMAINS         = 2,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned BLINK_CYCLES        = 3_000_000
) (
  input  logic                   cmod_osc,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   clear_fault,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   fault,
  output logic [c_llc_w-1:0]     lock_loss_count,
  output logic [1:0]             status_led
);

  localparam int unsigned c_tmr_max = f_max(f_max(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES),
                                            f_max(PLL_RESET_CYCLES, STAGE_GAP_CYCLES));
  localparam int unsigned c_tmr_w   = f_cnt_w(c_tmr_max);
  localparam int unsigned c_stg_w   = f_cnt_w(NUM_DOMAINS);
  localparam int unsigned c_rty_w   = f_cnt_w(MAX_RETRIES + 1);
  localparam int unsigned c_blk_w   = f_cnt_w(BLINK_CYCLES);

  localparam logic [c_tmr_w-1:0] c_rst_last = c_tmr_w'(PLL_RESET_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_tmo_last = c_tmr_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_stb_last = c_tmr_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_gap_last = c_tmr_w'(STAGE_GAP_CYCLES - 1);
  localparam logic [c_stg_w-1:0] c_stg_last = c_stg_w'(NUM_DOMAINS - 1);
  localparam logic [c_rty_w-1:0] c_rty_max  = c_rty_w'(MAX_RETRIES);
  localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_CYCLES - 1);

  state_e                 state_q;
  logic [c_tmr_w-1:0]     timer_q;
  logic [c_stg_w-1:0]     stage_q;
  logic [c_rty_w-1:0]     retries_q;
  logic [c_blk_w-1:0]     blink_q;
  logic                   pll_reset_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic                   fault_q;
  logic                   led_q;
  logic [c_llc_w-1:0]     llc_q;
  logic [c_llc_w-1:0]     llc_d;
  logic                   locked_s;

  sync_2ff u_lock_sync (
    .clk_i   (cmod_osc),
    .rst_n_i (reset_n),
    .d_i     (pll_locked),
    .q_o     (locked_s)
  );

  always_comb begin
    llc_d = (llc_q == '1) ? llc_q : llc_q + 1'b1;
  end

  always_ff @(posedge cmod_osc or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      stage_q     <= '0;
      retries_q   <= '0;
      blink_q     <= '0;
      pll_reset_q <= 1'b1;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      led_q       <= 1'b0;
      llc_q       <= '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (timer_q == c_rst_last) begin
            timer_q     <= '0;
            pll_reset_q <= 1'b0;
            state_q     <= WAIT_LOCK;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        // Timeout is tested before lock so a coincident lock rise loses.
        WAIT_LOCK: begin
          if (timer_q == c_tmo_last) begin
            timer_q     <= '0;
            pll_reset_q <= 1'b1;
            if (retries_q == c_rty_max) begin
              fault_q <= 1'b1;
              led_q   <= 1'b1;
              blink_q <= '0;
              state_q <= FAULT;
            end else begin
              retries_q <= retries_q + 1'b1;
              state_q   <= PLL_RST;
            end
          end else if (locked_s) begin
            timer_q <= '0;
            state_q <= STABLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        STABLE: begin
          if (!locked_s) begin
            timer_q <= '0;
            state_q <= WAIT_LOCK;
          end else if (timer_q == c_stb_last) begin
            timer_q <= '0;
            stage_q <= '0;
            dom_q   <= NUM_DOMAINS'(1);
            state_q <= RELEASE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        // Lock loss during release is handled exactly like loss in RUN and
        // takes priority over any pending stage advance.
        RELEASE, RUN: begin
          if (!locked_s) begin
            dom_q       <= '0;
            ready_q     <= 1'b0;
            llc_q       <= llc_d;
            retries_q   <= '0;
            timer_q     <= '0;
            pll_reset_q <= 1'b1;
            state_q     <= PLL_RST;
          end else if (state_q == RELEASE) begin
            if (timer_q == c_gap_last) begin
              timer_q <= '0;
              if (stage_q == c_stg_last) begin
                ready_q <= 1'b1;
                state_q <= RUN;
              end else begin
                stage_q <= stage_q + 1'b1;
                dom_q   <= (dom_q << 1) | NUM_DOMAINS'(1);
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end

        FAULT: begin
          if (clear_fault) begin
            fault_q   <= 1'b0;
            led_q     <= 1'b0;
            retries_q <= '0;
            timer_q   <= '0;
            state_q   <= PLL_RST;
          end else if (blink_q == c_blk_last) begin
            blink_q <= '0;
            led_q   <= ~led_q;
          end else begin
            blink_q <= blink_q + 1'b1;
          end
        end

        default: begin
          timer_q     <= '0;
          pll_reset_q <= 1'b1;
          dom_q       <= '0;
          ready_q     <= 1'b0;
          state_q     <= PLL_RST;
        end
      endcase
    end
  end

  assign pll_reset       = pll_reset_q;
  assign domain_rst_n    = dom_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign lock_loss_count = llc_q;
  assign status_led      = {led_q, ready_q};

endmodule
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_supervisor
// Brief    : Scoreboard bench: stimulus queues expected output changes with
//            the cycle they must appear in; a monitor matches every change.
// Revision : 1.0
// ============================================================================
module tb_pll_supervisor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       clear_fault;
  logic       pll_reset;
  logic [2:0] domain_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_count;
  logic [1:0] status_led;

  pll_supervisor #(
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (20),
    .PLL_RESET_CYCLES    (4),
    .MAX_RETRIES         (2),
    .NUM_DOMAINS         (3),
    .STAGE_GAP_CYCLES    (4),
    .BLINK_CYCLES        (5)
  ) dut (
    .cmod_osc        (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .clear_fault     (clear_fault),
    .pll_reset       (pll_reset),
    .domain_rst_n    (domain_rst_n),
    .ready           (ready),
    .fault           (fault),
    .lock_loss_count (lock_loss_count),
    .status_led      (status_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          q_cyc[$];
  logic [15:0] q_val[$];
  string       q_name[$];

  logic [15:0] act;
  assign act = {lock_loss_count, pll_reset, domain_rst_n, ready, fault, status_led};

  function automatic logic [15:0] mk(input int llc, input logic pr, input logic [2:0] dom,
                                     input logic rdy, input logic flt, input logic led1);
    return {8'(llc), pr, dom, rdy, flt, led1, rdy};
  endfunction

  task automatic ex(input int at, input string nm, input int llc, input logic pr,
                    input logic [2:0] dom, input logic rdy, input logic flt, input logic led1);
    q_cyc.push_back(at);
    q_name.push_back(nm);
    q_val.push_back(mk(llc, pr, dom, rdy, flt, led1));
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the output bundle must match the next expectation.
  initial begin
    logic [15:0] prev;
    int          ec;
    logic [15:0] ev;
    string       en;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (act !== prev) begin
        checks++;
        if (q_cyc.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc %0d got %h, required no change", cyc, act);
        end else begin
          ec = q_cyc.pop_front();
          ev = q_val.pop_front();
          en = q_name.pop_front();
          if (ec != cyc || ev !== act) begin
            errors++;
            $display("FAIL %s: got %h at cyc %0d, required %h at cyc %0d", en, act, cyc, ev, ec);
          end
        end
        prev = act;
      end
    end
  end

  initial begin
    int a;
    int d;
    int llc;
    reset_n     = 1'b1;
    pll_locked  = 1'b0;
    clear_fault = 1'b0;

    // Reset state and nominal start (reset released at cyc 2).
    ex(1,  "reset_state",    0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(6,  "pll_reset_fall", 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(24, "nom_dom0",       0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    ex(28, "nom_dom1",       0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    ex(32, "nom_dom2",       0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    ex(36, "nom_ready",      0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    wait_cyc(2);  reset_n = 1'b1;
    wait_cyc(13); pll_locked = 1'b1;
    // clear_fault outside FAULT must not change anything.
    wait_cyc(38); clear_fault = 1'b1;
    wait_cyc(39); clear_fault = 1'b0;

    // Lock loss in RUN, then a one-cycle glitch at stable count 5.
    a = 44;
    ex(a + 3,  "loss1",          1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 7,  "loss1_pr_fall",  1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 23, "glitch_dom0",    1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    ex(a + 27, "glitch_dom1",    1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    ex(a + 31, "glitch_dom2",    1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    ex(a + 35, "glitch_ready",   1, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    wait_cyc(a);      pll_locked = 1'b0;
    wait_cyc(a + 5);  pll_locked = 1'b1;
    wait_cyc(a + 11); pll_locked = 1'b0;
    wait_cyc(a + 12); pll_locked = 1'b1;

    // Repeated RUN lock losses; counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      a   = 84 + 30 * i;
      llc = (2 + i > 255) ? 255 : 2 + i;
      ex(a + 3,  "rep_loss",    llc, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      ex(a + 7,  "rep_pr_fall", llc, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      ex(a + 16, "rep_dom0",    llc, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      ex(a + 20, "rep_dom1",    llc, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
      ex(a + 24, "rep_dom2",    llc, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
      ex(a + 28, "rep_ready",   llc, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
      wait_cyc(a);     pll_locked = 1'b0;
      wait_cyc(a + 1); pll_locked = 1'b1;
    end

    // Asynchronous reset mid-RUN (lock stays high).
    a = 9090;
    ex(a + 1,  "async_reset",      0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 6,  "async_pr_fall",    0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 15, "async_dom0",       0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    wait_cyc(a);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (act !== mk(0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h, required %h", act,
               mk(0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0));
    end
    wait_cyc(a + 2); reset_n = 1'b1;

    // Lock loss landing on the first stage-advance edge of RELEASE.
    d = a + 15;
    ex(d + 4,  "rel_loss",    1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(d + 8,  "rel_pr_fall", 1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(d + 17, "rel_dom0",    1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    ex(d + 21, "rel_dom1",    1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    ex(d + 25, "rel_dom2",    1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    ex(d + 29, "rel_ready",   1, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    wait_cyc(d + 1); pll_locked = 1'b0;
    wait_cyc(d + 2); pll_locked = 1'b1;

    // Never locks: three pulses, FAULT, blink, clear, then timeout-vs-lock race.
    a = 9140;
    ex(a + 3,   "nl_loss",        2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 7,   "nl_pulse1_fall", 2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 27,  "nl_pulse2_rise", 2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 31,  "nl_pulse2_fall", 2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 51,  "nl_pulse3_rise", 2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 55,  "nl_pulse3_fall", 2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 75,  "fault_entry",    2, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    ex(a + 80,  "blink_off",      2, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    ex(a + 85,  "blink_on",       2, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    ex(a + 88,  "fault_clear",    2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 92,  "clr_pr_fall",    2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 112, "timeout_wins",   2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 116, "tw_pr_fall",     2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    ex(a + 125, "tw_dom0",        2, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    ex(a + 129, "tw_dom1",        2, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    ex(a + 133, "tw_dom2",        2, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    ex(a + 137, "tw_ready",       2, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    wait_cyc(a);       pll_locked  = 1'b0;
    wait_cyc(a + 87);  clear_fault = 1'b1;
    wait_cyc(a + 88);  clear_fault = 1'b0;
    wait_cyc(a + 109); pll_locked  = 1'b1;
    wait_cyc(a + 145);

    while (q_cyc.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no change, required %h at cyc %0d",
               q_name.pop_front(), q_val.pop_front(), q_cyc.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
